// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_queue
//  Description : Instruction prefetch queue ahead of the IF stage. Issues word
//                fetches and buffers in-order responses, flushing on redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFWrite,
    input  logic        redirect,
    input  logic [31:0] JumpAddr,
    output logic [31:0] PC,
    output logic [31:0] Instruction_if,
    output logic        inst_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);

    localparam int AW = $clog2(DEPTH);
    // Fetches marked for discard do not count toward the issue limit, so
    // inflight can briefly exceed DEPTH after a redirect; counters get headroom.
    localparam int CW = AW + 3;
    localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [31:0]   r_fpc;
    logic [31:0]   r_ret_pc;
    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_occ;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;

    logic [CW-1:0] w_outstanding;
    logic [CW-1:0] w_level;
    logic [CW-1:0] w_inflight_ret;
    logic [31:0]   w_target;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_discard;
    logic          w_unused_ok;

    assign w_target       = {JumpAddr[31:2], 2'b00};
    assign w_unused_ok    = ^JumpAddr[1:0];
    assign w_outstanding  = r_inflight - r_drop;
    assign w_level        = CW'(r_occ) + w_outstanding;
    assign w_inflight_ret = r_inflight - CW'(imem_rvalid);

    assign inst_valid     = (r_occ != '0);
    assign imem_req       = reset && !redirect && (w_level < c_depth);
    assign imem_addr      = r_fpc;
    assign w_grant        = imem_req && imem_gnt;
    assign w_discard      = imem_rvalid && (r_drop != '0);
    assign w_push         = reset && !redirect && imem_rvalid && (r_drop == '0);
    assign w_pop          = IFWrite && inst_valid && !redirect;

    // When empty, PC shows the address of the next instruction expected back.
    assign Instruction_if = inst_valid ? r_instr_mem[r_rd_ptr] : NOP;
    assign PC             = inst_valid ? r_pc_mem[r_rd_ptr] : r_ret_pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fpc      <= RESET_PC;
            r_ret_pc   <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect) begin
            // Everything still owed by memory, minus this cycle's response,
            // belongs to the old stream and must be thrown away.
            r_fpc      <= w_target;
            r_ret_pc   <= w_target;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_inflight <= w_inflight_ret;
            r_drop     <= w_inflight_ret;
        end else begin
            if (w_grant) begin
                r_fpc <= r_fpc + 32'd4;
            end
            r_inflight <= w_inflight_ret + CW'(w_grant);
            if (w_discard) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                r_ret_pc <= r_ret_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_occ <= r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_ret_pc;
            r_instr_mem[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_queue
//  Description : Randomized self-checking bench for inst_fetch_queue against a
//                queue-based model, with directed literal anchors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        IFWrite = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] JumpAddr = '0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] PC;
    logic [31:0] Instruction_if;
    logic        inst_valid;
    logic        imem_req;
    logic [31:0] imem_addr;

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP      (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .IFWrite        (IFWrite),
        .redirect       (redirect),
        .JumpAddr       (JumpAddr),
        .PC             (PC),
        .Instruction_if (Instruction_if),
        .inst_valid     (inst_valid),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    typedef struct { int due; logic [31:0] addr; } fetch_t;

    entry_t      mq[$];     // expected queue contents, head first
    fetch_t      memq[$];   // fetches the memory model still owes
    logic [31:0] m_fpc;
    logic [31:0] m_ret;
    int          m_inflight;
    int          m_drop;
    int          cyc;
    int          last_due;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        mq.delete();
        memq.delete();
        m_fpc      = RESET_PC;
        m_ret      = RESET_PC;
        m_inflight = 0;
        m_drop     = 0;
        last_due   = 0;
    endtask

    task automatic mem_drive();
        if (reset && memq.size() > 0 && memq[0].due <= cyc + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(memq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    function automatic bit model_req();
        return reset && !redirect && (mq.size() + m_inflight - m_drop < DEPTH);
    endfunction

    task automatic compare();
        chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("Instruction_if", Instruction_if, mq[0].instr);
            chk("PC", PC, mq[0].pc);
        end else begin
            chk("Instruction_if_nop", Instruction_if, NOP);
        end
        chk("imem_req", 32'(imem_req), 32'(model_req()));
        chk("imem_addr", imem_addr, m_fpc);
    endtask

    task automatic model_update(input bit grant);
        int due;
        if (!reset) begin
            model_reset();
            return;
        end
        if (imem_rvalid) void'(memq.pop_front());
        if (redirect) begin
            mq.delete();
            m_inflight = m_inflight - int'(imem_rvalid);
            m_drop     = m_inflight;
            m_fpc      = JumpAddr & 32'hFFFF_FFFC;
            m_ret      = m_fpc;
        end else begin
            if (IFWrite && mq.size() > 0) void'(mq.pop_front());
            if (imem_rvalid) begin
                m_inflight--;
                if (m_drop > 0) m_drop--;
                else begin
                    mq.push_back('{pc: m_ret, instr: imem_rdata});
                    m_ret = m_ret + 32'd4;
                end
            end
            if (grant) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{due: due, addr: m_fpc});
                m_fpc = m_fpc + 32'd4;
                m_inflight++;
            end
        end
    endtask

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic step();
        bit grant;
        mem_drive();
        #1;
        compare();
        grant = model_req() && imem_gnt;
        @(posedge clk);
        cyc++;
        model_update(grant);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (inst_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) chk({name, "_timeout"}, 32'(inst_valid), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset, then a streaming L=1 memory with the pipeline always consuming.
        IFWrite  = 1'b1;
        imem_gnt = 1'b1;
        repeat (3) step();
        chk("reset_PC", PC, RESET_PC);
        chk("reset_addr", imem_addr, RESET_PC);
        chk("reset_req", 32'(imem_req), 32'd0);
        reset = 1'b1;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
        step();
        chk("second_addr", imem_addr, RESET_PC + 32'd4);
        step();
        chk("first_valid", 32'(inst_valid), 32'd1);
        chk("first_PC", PC, RESET_PC);
        chk("first_instr", Instruction_if, mem_data(RESET_PC));
        step();
        chk("stream_PC1", PC, RESET_PC + 32'd4);
        step();
        chk("stream_PC2", PC, RESET_PC + 32'd8);

        // Backpressure: fill the queue, then release one pop.
        IFWrite = 1'b0;
        repeat (8) step();
        chk("full_req_low", 32'(imem_req), 32'd0);
        chk("full_valid", 32'(inst_valid), 32'd1);
        IFWrite = 1'b1;
        step();
        IFWrite = 1'b0;
        #1;
        chk("reenable_req", 32'(imem_req), 32'd1);
        step();
        chk("single_req", 32'(imem_req), 32'd0);
        step();

        // Redirect with fetches in flight, L=3, aligned and unaligned target.
        IFWrite = 1'b1;
        lat_min = 3;
        lat_max = 3;
        repeat (6) step();
        for (int k = 0; k < 2; k++) begin
            redirect = 1'b1;
            JumpAddr = (k == 0) ? 32'h0000_0040 : 32'h0000_0043;
            step();
            redirect = 1'b0;
            #1;
            chk("redir_valid", 32'(inst_valid), 32'd0);
            chk("redir_req", 32'(imem_req), 32'd1);
            chk("redir_addr", imem_addr, 32'h0000_0040);
            wait_valid("redir");
            chk("redir_head_PC", PC, 32'h0000_0040);
            repeat (3) step();
        end

        // Redirect landing on a cycle with a response returning.
        lat_min = 1;
        lat_max = 1;
        repeat (6) step();
        for (int i = 0; i < 10; i++) begin
            if (memq.size() > 0 && memq[0].due <= cyc + 1) break;
            step();
        end
        redirect = 1'b1;
        JumpAddr = 32'h0000_0100;
        step();
        redirect = 1'b0;
        wait_valid("coinc");
        chk("coinc_head_PC", PC, 32'h0000_0100);

        // PC wrap-around at the top of the address space.
        redirect = 1'b1;
        JumpAddr = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        wait_valid("wrap");
        chk("wrap_PC0", PC, 32'hFFFF_FFF8);
        step();
        chk("wrap_PC1", PC, 32'hFFFF_FFFC);
        step();
        chk("wrap_PC2", PC, 32'h0000_0000);

        // Full queue streaming through pointer wrap over 3*DEPTH entries.
        IFWrite = 1'b0;
        repeat (8) step();
        IFWrite = 1'b1;
        repeat (3 * DEPTH + 4) step();

        // Reset mid-operation with occ=3 and one fetch in flight.
        IFWrite  = 1'b0;
        lat_min  = 2;
        lat_max  = 2;
        redirect = 1'b1;
        JumpAddr = 32'h0000_0200;
        step();
        redirect = 1'b0;
        repeat (5) step();
        reset = 1'b0;
        step();
        chk("mid_reset_valid", 32'(inst_valid), 32'd0);
        chk("mid_reset_instr", Instruction_if, NOP);
        chk("mid_reset_PC", PC, RESET_PC);
        reset   = 1'b1;
        IFWrite = 1'b1;
        wait_valid("restart");
        chk("restart_PC", PC, RESET_PC);

        // Randomized traffic with variable latency, stalls, redirects, resets.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) != 0);
            IFWrite  = ($urandom_range(0, 3) != 0);
            imem_gnt = ($urandom_range(0, 3) != 0);
            redirect = reset && ($urandom_range(0, 24) == 0);
            JumpAddr = $urandom_range(0, 1) ? 32'($urandom)
                                            : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
